// File: rtl/dmem_arb_pkg.sv
// Shared types, constants and the address legality check for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned WORD_OFFSET = 3;

  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_DMA = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCKED_0 = 2'd1,
    LOCKED_1 = 2'd2
  } arb_state_e;

  // Registered per-requester response payload.
  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // A byte address is legal when word aligned and inside the memory.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth);
    logic [ADDR_W-1:0] limit;
    limit = ADDR_W'(depth) << WORD_OFFSET;
    return (addr[WORD_OFFSET-1:0] == '0) && (addr < limit);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick with an optional forced owner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_en,
  input  logic       force_id,
  output logic [1:0] gnt
);

  // Forced owner may only be granted itself; otherwise a tie goes to !last.
  always_comb begin
    gnt = 2'b00;
    if (force_en) begin
      gnt[force_id] = req[force_id];
    end else if (req == 2'b11) begin
      gnt[~last] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU (0) and DMA (1) with round-robin
// arbitration, bounded locked bursts and a one-cycle registered response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_0,
  input  logic              WE_0,
  input  logic              LOCK_0,
  input  logic [ADDR_W-1:0] ADDR_0,
  input  logic [DATA_W-1:0] WDATA_0,
  output logic              GNT_0,
  output logic              RVALID_0,
  output logic [DATA_W-1:0] RDATA_0,
  output logic              ERR_0,
  input  logic              REQ_1,
  input  logic              WE_1,
  input  logic              LOCK_1,
  input  logic [ADDR_W-1:0] ADDR_1,
  input  logic [DATA_W-1:0] WDATA_1,
  output logic              GNT_1,
  output logic              RVALID_1,
  output logic [DATA_W-1:0] RDATA_1,
  output logic              ERR_1,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WR_DATA,
  input  logic [DATA_W-1:0] MEM_RD_DATA
);

  localparam int unsigned CNT_RAW = $clog2(MAX_BURST + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 3) ? CNT_RAW : 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  rsp_t             rsp_q [2];
  rsp_t             rsp_d [2];

  logic [1:0]        req_v;
  logic [1:0]        lock_v;
  logic [1:0]        gnt_raw;
  logic [1:0]        gnt;
  logic              in_lock;
  logic              lock_own;
  logic              lock_hold;
  logic              forced_rel;
  logic              last_eff;
  logic              any_gnt;
  logic              win;
  logic              we_w;
  logic              lock_w;
  logic              legal;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] wdata_w;

  assign req_v  = {REQ_1, REQ_0};
  assign lock_v = {LOCK_1, LOCK_0};

  // Lock qualification: owner keeps the port while it asks and has budget left.
  assign in_lock    = (state_q != IDLE);
  assign lock_own   = (state_q == LOCKED_1);
  assign lock_hold  = in_lock && lock_v[lock_own] && (cnt_q < CNT_MAX);
  assign forced_rel = in_lock && (cnt_q == CNT_MAX);
  assign last_eff   = forced_rel ? lock_own : last_q;

  rr_arb2 u_rr_arb2 (
    .req      (req_v),
    .last     (last_eff),
    .force_en (lock_hold),
    .force_id (lock_own),
    .gnt      (gnt_raw)
  );

  // Winner mux, memory port drive, next FSM state and response payloads.
  always_comb begin
    gnt         = RST ? 2'b00 : gnt_raw;
    any_gnt     = |gnt;
    win         = gnt[1];
    we_w        = win ? WE_1    : WE_0;
    lock_w      = win ? LOCK_1  : LOCK_0;
    addr_w      = win ? ADDR_1  : ADDR_0;
    wdata_w     = win ? WDATA_1 : WDATA_0;
    legal       = addr_legal(addr_w, DEPTH);

    MEM_READ    = any_gnt && legal && !we_w;
    MEM_WRITE   = any_gnt && legal && we_w;
    MEM_ADDR    = any_gnt ? (addr_w >> WORD_OFFSET) : '0;
    MEM_WR_DATA = any_gnt ? wdata_w : '0;

    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    if (lock_hold) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
      if (any_gnt && lock_w) begin
        state_d = win ? LOCKED_1 : LOCKED_0;
        cnt_d   = CNT_W'(1);
      end
    end
    if (any_gnt) begin
      last_d = win;
    end

    for (int i = 0; i < 2; i++) begin
      rsp_d[i].valid = gnt[i];
      rsp_d[i].err   = gnt[i] && !legal;
      rsp_d[i].data  = (gnt[i] && legal && !we_w) ? MEM_RD_DATA : '0;
    end
  end

  // State, lock counter, round-robin pointer and response registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        rsp_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      for (int i = 0; i < 2; i++) begin
        rsp_q[i] <= rsp_d[i];
      end
    end
  end

  assign GNT_0    = gnt[REQ_CPU];
  assign GNT_1    = gnt[REQ_DMA];
  assign RVALID_0 = rsp_q[REQ_CPU].valid;
  assign ERR_0    = rsp_q[REQ_CPU].err;
  assign RDATA_0  = rsp_q[REQ_CPU].data;
  assign RVALID_1 = rsp_q[REQ_DMA].valid;
  assign ERR_1    = rsp_q[REQ_DMA].err;
  assign RDATA_1  = rsp_q[REQ_DMA].data;

endmodule
